// File: rtl/buzz_sched.sv
// buzz_sched: shares one piezo buzzer among alarm, hourly chime and key beep and sequences their tone patterns
module buzz_sched #(
  parameter int          TICK_DIV     = 50000,
  parameter int          BEEP_MS      = 50,
  parameter int          CHIME_MS     = 500,
  parameter int          ALARM_ON_MS  = 250,
  parameter int          ALARM_OFF_MS = 250,
  parameter int          ALARM_MAX    = 120,
  parameter logic [31:0] TONE_BEEP    = 32'd11958,
  parameter logic [31:0] TONE_CHIME   = 32'd17916,
  parameter logic [31:0] TONE_ALARM   = 32'd14220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_alarm_req,
  input  logic        i_chime_pls,
  input  logic        i_key_pls,
  input  logic        i_stop_pls,
  output logic        o_buzz_en,
  output logic [31:0] o_nco_num,
  output logic [1:0]  o_grant,
  output logic        o_alarm_done
);
  typedef enum logic [2:0] {IDLE, BEEP, CHIME, AL_ON, AL_OFF} state_t;
  state_t      state_q, state_d;
  logic        chime_q, chime_d, key_q, key_d, al_q, done_d, enter;
  logic        in_al, rise, tick, dur_end;
  logic [31:0] pre_q;
  logic [15:0] ms_q, dur;
  logic [7:0]  pair_q, pair_d;
  assign in_al   = state_q == AL_ON || state_q == AL_OFF;
  assign rise    = i_alarm_req && !al_q && !i_stop_pls;
  assign tick    = pre_q == 32'(TICK_DIV - 1);
  assign dur     = state_q == BEEP ? 16'(BEEP_MS) : state_q == CHIME ? 16'(CHIME_MS) :
                   state_q == AL_ON ? 16'(ALARM_ON_MS) : 16'(ALARM_OFF_MS);
  assign dur_end = tick && ms_q == dur - 16'd1;
  // next state: alarm edge first, then alarm exit, alarm phasing, and finally chime/beep arbitration
  always_comb begin
    state_d = state_q;
    chime_d = in_al ? chime_q : chime_q | i_chime_pls;
    key_d   = in_al ? key_q : key_q | i_key_pls;
    pair_d  = pair_q;
    done_d  = 1'b0;
    enter   = 1'b0;
    if (rise) begin
      state_d = AL_ON;
      chime_d = 1'b0;
      key_d   = 1'b0;
      pair_d  = '0;
      enter   = 1'b1;
    end else if (in_al && (i_stop_pls || !i_alarm_req)) begin
      state_d = IDLE;
      enter   = 1'b1;
    end else if (state_q == AL_ON && dur_end) begin
      state_d = AL_OFF;
      enter   = 1'b1;
    end else if (state_q == AL_OFF && dur_end) begin
      enter   = 1'b1;
      done_d  = pair_q == 8'(ALARM_MAX - 1);
      state_d = done_d ? IDLE : AL_ON;
      pair_d  = pair_q + 8'd1;
    end else if (state_q == IDLE || dur_end) begin
      enter   = 1'b1;
      state_d = chime_d ? CHIME : key_d ? BEEP : IDLE;
      key_d   = key_d && chime_d;
      chime_d = 1'b0;
    end
  end
  // state, timers and registered outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      chime_q      <= 1'b0;
      key_q        <= 1'b0;
      al_q         <= 1'b0;
      pre_q        <= '0;
      ms_q         <= '0;
      pair_q       <= '0;
      o_buzz_en    <= 1'b0;
      o_nco_num    <= '0;
      o_grant      <= '0;
      o_alarm_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      chime_q      <= chime_d;
      key_q        <= key_d;
      al_q         <= i_alarm_req;
      pair_q       <= pair_d;
      pre_q        <= enter || tick ? '0 : pre_q + 32'd1;
      ms_q         <= enter ? '0 : tick ? ms_q + 16'd1 : ms_q;
      o_buzz_en    <= state_d == BEEP || state_d == CHIME || state_d == AL_ON;
      o_nco_num    <= state_d == BEEP ? TONE_BEEP : state_d == CHIME ? TONE_CHIME :
                      state_d == AL_ON ? TONE_ALARM : '0;
      o_grant      <= state_d == IDLE ? 2'b00 : state_d == BEEP ? 2'b01 :
                      state_d == CHIME ? 2'b10 : 2'b11;
      o_alarm_done <= done_d;
    end
  end
endmodule

// File: tb/tb_buzz_sched.sv
// tb_buzz_sched: scenario and randomized checks of buzz_sched against a countdown-based behavioural model
module tb_buzz_sched;
  localparam int T = 4, BMS = 2, CMS = 3, ONMS = 2, OFFMS = 2, AMAX = 3;
  logic        clk = 0, rst = 1, i_alarm_req = 0, i_chime_pls = 0, i_key_pls = 0, i_stop_pls = 0;
  logic        o_buzz_en, o_alarm_done;
  logic [31:0] o_nco_num;
  logic [1:0]  o_grant;
  int checks = 0, errors = 0;
  int m_mode, m_rem, m_pairs;
  bit m_ch, m_ky, m_prev, m_done, lvl;
  wire [35:0] act = {o_buzz_en, o_grant, o_nco_num, o_alarm_done};

  buzz_sched #(.TICK_DIV(T), .BEEP_MS(BMS), .CHIME_MS(CMS), .ALARM_ON_MS(ONMS),
               .ALARM_OFF_MS(OFFMS), .ALARM_MAX(AMAX)) dut (
    .clk(clk), .rst(rst), .i_alarm_req(i_alarm_req), .i_chime_pls(i_chime_pls),
    .i_key_pls(i_key_pls), .i_stop_pls(i_stop_pls), .o_buzz_en(o_buzz_en),
    .o_nco_num(o_nco_num), .o_grant(o_grant), .o_alarm_done(o_alarm_done));

  always #5 clk = ~clk;

  // mode: 0 silent, 1 beep, 2 chime, 3 alarm tone, 4 alarm gap; m_rem counts cycles left in mode
  function automatic logic [35:0] exp_vec();
    logic [31:0] n;
    logic [1:0]  g;
    n = m_mode == 1 ? 32'd11958 : m_mode == 2 ? 32'd17916 : m_mode == 3 ? 32'd14220 : 32'd0;
    g = m_mode == 4 ? 2'd3 : 2'(m_mode);
    return {m_mode >= 1 && m_mode <= 3, g, n, m_done};
  endfunction

  task automatic model(input bit ar, ch, ky, sp);
    bit rise, al;
    rise = ar && !m_prev;
    m_prev = ar;
    al = m_mode >= 3;
    m_done = 0;
    if (!al) begin
      m_ch = m_ch | ch;
      m_ky = m_ky | ky;
    end
    if (m_mode != 0) m_rem--;
    if (rise && !sp) begin
      m_mode = 3; m_rem = ONMS * T; m_ch = 0; m_ky = 0; m_pairs = 0;
    end else if (al && (sp || !ar)) m_mode = 0;
    else if (m_mode == 3 && m_rem == 0) begin
      m_mode = 4; m_rem = OFFMS * T;
    end else if (m_mode == 4 && m_rem == 0) begin
      m_pairs++;
      if (m_pairs == AMAX) begin
        m_mode = 0; m_done = 1;
      end else begin
        m_mode = 3; m_rem = ONMS * T;
      end
    end else if (m_mode == 0 || m_rem == 0) begin
      if (m_ch) begin
        m_mode = 2; m_rem = CMS * T; m_ch = 0;
      end else if (m_ky) begin
        m_mode = 1; m_rem = BMS * T; m_ky = 0;
      end else m_mode = 0;
    end
  endtask

  task automatic step(input bit ch, ky, sp, r);
    i_alarm_req = lvl; i_chime_pls = ch; i_key_pls = ky; i_stop_pls = sp; rst = r;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_rem = 0; m_pairs = 0; m_ch = 0; m_ky = 0; m_prev = 0; m_done = 0;
    end else model(lvl, ch, ky, sp);
    #1;
    i_chime_pls = 0; i_key_pls = 0; i_stop_pls = 0; rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, i == 1, 0, 1);
      checks++;
      if (act !== 36'd0) begin errors++; $display("FAIL reset cyc %0d got %h want 0", i, act); end
    end
  endtask

  task automatic test_key_beep();
    int on = 0;
    step(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL key_beep cyc %0d got %h want %h", i, act, exp_vec()); end
      if (o_buzz_en) begin
        on++;
        checks++;
        if (o_grant !== 2'b01 || o_nco_num !== 32'd11958) begin
          errors++; $display("FAIL key_beep_tone got %b/%0d want 01/11958", o_grant, o_nco_num);
        end
      end
      step(0, 0, 0, 0);
    end
    checks++;
    if (on != 8) begin errors++; $display("FAIL key_beep_len got %0d want 8", on); end
  endtask

  task automatic test_chime_key();
    int nc = 0, nb = 0, order_ok = 1;
    step(1, 1, 0, 0);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL chime_key cyc %0d got %h want %h", i, act, exp_vec()); end
      if (o_grant == 2'b10) begin nc++; if (nb != 0) order_ok = 0; end
      if (o_grant == 2'b01) nb++;
      step(0, 0, 0, 0);
    end
    checks++;
    if (nc != 12 || nb != 8 || !order_ok) begin
      errors++; $display("FAIL chime_key_seq got chime %0d beep %0d order %0d want 12 8 1", nc, nb, order_ok);
    end
  endtask

  task automatic test_alarm_preempt();
    int on = 0, dn = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    lvl = 1;
    step(0, 0, 0, 0);
    checks++;
    if (o_grant !== 2'b11 || o_nco_num !== 32'd14220) begin
      errors++; $display("FAIL alarm_preempt got %b/%0d want 11/14220", o_grant, o_nco_num);
    end
    for (int i = 0; i < 52; i++) begin
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL alarm_run cyc %0d got %h want %h", i, act, exp_vec()); end
      on += o_buzz_en;
      dn += o_alarm_done;
      step(0, 0, 0, 0);
    end
    checks++;
    if (on != 24 || dn != 1 || o_grant !== 2'b00) begin
      errors++; $display("FAIL alarm_auto got on %0d done %0d grant %b want 24 1 00", on, dn, o_grant);
    end
    lvl = 0;
    step(0, 0, 0, 0);
  endtask

  task automatic test_stop();
    lvl = 1;
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0);
    checks++;
    if (o_grant !== 2'b11 || o_buzz_en !== 1'b0) begin
      errors++; $display("FAIL stop_pre got %b/%b want 11/0", o_grant, o_buzz_en);
    end
    step(0, 0, 1, 0);
    checks++;
    if (act !== exp_vec() || o_grant !== 2'b00 || o_alarm_done !== 1'b0) begin
      errors++; $display("FAIL stop_alarm got %h want %h", act, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, i == 1, 0);
      checks++;
      if (act !== 36'd0) begin errors++; $display("FAIL stop_idle cyc %0d got %h want 0", i, act); end
    end
    lvl = 0;
    step(0, 0, 0, 0);
  endtask

  task automatic test_key_in_alarm();
    int on = 0;
    lvl = 1;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    lvl = 0;
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL key_alarm cyc %0d got %h want %h", i, act, exp_vec()); end
      on += o_buzz_en;
      step(0, 0, 0, 0);
    end
    checks++;
    if (on != 0) begin errors++; $display("FAIL key_discard got %0d buzz cycles want 0", on); end
  endtask

  task automatic test_reset_mid_beep();
    int on = 0;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if (act !== 36'd0) begin errors++; $display("FAIL reset_mid got %h want 0", act); end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      on += o_buzz_en;
    end
    checks++;
    if (on != 0) begin errors++; $display("FAIL reset_pend got %0d buzz cycles want 0", on); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lvl = !lvl;
      step($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 799) == 0);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %h want %h", i, act, exp_vec()); end
    end
  endtask

  initial begin
    lvl = 0;
    test_reset();
    test_key_beep();
    test_chime_key();
    test_alarm_preempt();
    test_stop();
    test_key_in_alarm();
    test_reset_mid_beep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
